// File: rtl/netdma_pkg.sv
// Shared register map, CTRL/STATUS bit positions and channel state encoding
// for the NetDMA interrupt coalescer.
package netdma_pkg;

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_TIMEOUT = 2'd1;
    localparam logic [1:0] OFF_STATUS  = 2'd2;
    localparam logic [1:0] OFF_RSVD    = 2'd3;

    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_LATCH_BIT = 1;
    localparam int CTRL_THR_LSB   = 8;

    localparam int STATUS_IRQ_BIT     = 0;
    localparam int STATUS_COLLECT_BIT = 1;
    localparam int STATUS_CNT_LSB     = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FIRE    = 2'd2
    } chan_state_e;

endpackage

// File: rtl/netdma_irq_coalesce_channel.sv
// One interrupt-coalescing channel: its CTRL/TIMEOUT registers, batch FSM
// and registered irq output.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no batch open, count and timer held at 0
// ST_COLLECT | batch open, counting events and cycles since entry
// ST_FIRE    | single cycle after the fire decision, irq visible this cycle
module netdma_irq_coalesce_channel
    import netdma_pkg::*;
#(
    parameter int COUNT_W = 8,
    parameter int TIMER_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        event_i,
    input  logic        wr_ctrl_i,
    input  logic        wr_timeout_i,
    input  logic        wr_status_i,
    input  logic [31:0] writedata_i,
    output logic [31:0] ctrl_o,
    output logic [31:0] timeout_o,
    output logic [31:0] status_o,
    output logic        irq_o
);

    logic               r_en;
    logic               r_latch;
    logic [COUNT_W-1:0] r_thr;
    logic [TIMER_W-1:0] r_tmo;
    logic [COUNT_W-1:0] r_cnt;
    logic [TIMER_W-1:0] r_tmr;
    chan_state_e        r_state;
    logic               r_irq;

    logic               w_en_nxt;
    logic [COUNT_W-1:0] w_cnt_inc;
    logic [COUNT_W-1:0] w_thr_eff;
    logic               w_tmo_hit;
    logic               w_fire;
    logic               w_clr;
    logic               w_wdata_unused;

    // Disabling acts in the same edge that writes CTRL, so the channel is idle next cycle.
    assign w_en_nxt  = wr_ctrl_i ? writedata_i[CTRL_EN_BIT] : r_en;
    assign w_cnt_inc = (event_i && (r_cnt != '1)) ? r_cnt + COUNT_W'(1) : r_cnt;
    assign w_thr_eff = (r_thr == '0) ? COUNT_W'(1) : r_thr;
    assign w_tmo_hit = (r_tmo != '0) && (r_tmr == r_tmo - TIMER_W'(1));
    assign w_fire    = (r_state == ST_COLLECT) && ((w_cnt_inc >= w_thr_eff) || w_tmo_hit);
    assign w_clr     = wr_status_i && writedata_i[STATUS_IRQ_BIT];
    assign w_wdata_unused = ^writedata_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_en    <= 1'b0;
            r_latch <= 1'b0;
            r_thr   <= '0;
            r_tmo   <= '0;
        end else begin
            if (wr_ctrl_i) begin
                r_en    <= writedata_i[CTRL_EN_BIT];
                r_latch <= writedata_i[CTRL_LATCH_BIT];
                r_thr   <= writedata_i[CTRL_THR_LSB +: COUNT_W];
            end
            if (wr_timeout_i) begin
                r_tmo <= writedata_i[TIMER_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tmr   <= '0;
        end else if (!w_en_nxt) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tmr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tmr <= '0;
                    if (event_i) begin
                        r_state <= ST_COLLECT;
                        r_cnt   <= COUNT_W'(1);
                    end else begin
                        r_cnt <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (w_fire) begin
                        r_state <= ST_FIRE;
                        r_cnt   <= '0;
                        r_tmr   <= '0;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        r_tmr <= r_tmr + TIMER_W'(1);
                    end
                end
                ST_FIRE: begin
                    r_tmr   <= '0;
                    r_state <= event_i ? ST_COLLECT : ST_IDLE;
                    r_cnt   <= event_i ? COUNT_W'(1) : '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_tmr   <= '0;
                end
            endcase
        end
    end

    // A fire in the same cycle as a STATUS clear wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_irq <= 1'b0;
        end else if (!w_en_nxt) begin
            r_irq <= 1'b0;
        end else if (w_fire) begin
            r_irq <= 1'b1;
        end else if (!r_latch || w_clr) begin
            r_irq <= 1'b0;
        end
    end

    always_comb begin
        ctrl_o    = '0;
        timeout_o = '0;
        status_o  = '0;
        ctrl_o[CTRL_EN_BIT]                  = r_en;
        ctrl_o[CTRL_LATCH_BIT]               = r_latch;
        ctrl_o[CTRL_THR_LSB +: COUNT_W]      = r_thr;
        timeout_o[TIMER_W-1:0]               = r_tmo;
        status_o[STATUS_IRQ_BIT]             = r_irq;
        status_o[STATUS_COLLECT_BIT]         = (r_state == ST_COLLECT);
        status_o[STATUS_CNT_LSB +: COUNT_W]  = r_cnt;
    end

    assign irq_o = r_irq;

endmodule

// File: rtl/netdma_irq_coalescer.sv
// NetDMA interrupt coalescer top: CPU address decode, readback mux and
// per-channel coalescing instances.
module netdma_irq_coalescer
    import netdma_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int COUNT_W  = 8,
    parameter int TIMER_W  = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [CHANNELS-1:0]         event_i,
    input  logic                        write_i,
    input  logic                        read_i,
    input  logic [$clog2(CHANNELS)+1:0] address_i,
    input  logic [31:0]                 writedata_i,
    output logic [31:0]                 readdata_o,
    output logic [CHANNELS-1:0]         irq_o,
    output logic                        irq_any_o
);

    logic [31:0] w_chan;
    logic [1:0]  w_off;
    logic [31:0] w_ctrl    [CHANNELS];
    logic [31:0] w_timeout [CHANNELS];
    logic [31:0] w_status  [CHANNELS];

    // Channel indices past CHANNELS-1 match no instance, so they read 0 and drop writes.
    assign w_chan = 32'(address_i >> 2);
    assign w_off  = address_i[1:0];

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic w_sel;
        assign w_sel = write_i && (w_chan == 32'(g));

        netdma_irq_coalesce_channel #(
            .COUNT_W (COUNT_W),
            .TIMER_W (TIMER_W)
        ) u_chan (
            .clk_i        (clk_i),
            .rst_n_i      (rst_n_i),
            .event_i      (event_i[g]),
            .wr_ctrl_i    (w_sel && (w_off == OFF_CTRL)),
            .wr_timeout_i (w_sel && (w_off == OFF_TIMEOUT)),
            .wr_status_i  (w_sel && (w_off == OFF_STATUS)),
            .writedata_i  (writedata_i),
            .ctrl_o       (w_ctrl[g]),
            .timeout_o    (w_timeout[g]),
            .status_o     (w_status[g]),
            .irq_o        (irq_o[g])
        );
    end

    always_comb begin
        readdata_o = '0;
        if (read_i) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_chan == 32'(c)) begin
                    case (w_off)
                        OFF_CTRL:    readdata_o = w_ctrl[c];
                        OFF_TIMEOUT: readdata_o = w_timeout[c];
                        OFF_STATUS:  readdata_o = w_status[c];
                        default:     readdata_o = '0;
                    endcase
                end
            end
        end
    end

    assign irq_any_o = |irq_o;

endmodule

// File: tb/tb_netdma_irq_coalescer.sv
// Directed bench for the NetDMA interrupt coalescer: 4-channel main instance
// plus a 5-channel instance for out-of-range channel decode.
module tb_netdma_irq_coalescer;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ev;
    logic        wr;
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic [3:0]  irq;
    logic        irq_any;

    logic [4:0]  ev5;
    logic        wr5;
    logic        rd5;
    logic [4:0]  addr5;
    logic [31:0] rdata5;
    logic [4:0]  irq5;
    logic        irq_any5;

    int n_checks;
    int n_fail;

    netdma_irq_coalescer #(.CHANNELS(4), .COUNT_W(8), .TIMER_W(16)) u_dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .event_i     (ev),
        .write_i     (wr),
        .read_i      (rd),
        .address_i   (addr),
        .writedata_i (wd),
        .readdata_o  (rdata),
        .irq_o       (irq),
        .irq_any_o   (irq_any)
    );

    netdma_irq_coalescer #(.CHANNELS(5), .COUNT_W(8), .TIMER_W(16)) u_dut5 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .event_i     (ev5),
        .write_i     (wr5),
        .read_i      (rd5),
        .address_i   (addr5),
        .writedata_i (wd),
        .readdata_o  (rdata5),
        .irq_o       (irq5),
        .irq_any_o   (irq_any5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input int ch, input int off, input logic [31:0] d);
        addr = 4'(ch * 4 + off);
        wd   = d;
        wr   = 1'b1;
        tick();
        wr   = 1'b0;
    endtask

    task automatic cpu_rd(input int ch, input int off, output logic [31:0] d);
        addr = 4'(ch * 4 + off);
        rd   = 1'b1;
        #1;
        d    = rdata;
        rd   = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (irq !== 4'h0 || irq_any !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: irq=%h any=%b, required 0/0", irq, irq_any);
        end
        addr = 4'h0;
        #1;
        n_checks++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL read_idle_zero: rdata=%h, required 0", rdata);
        end
        cpu_rd(0, 0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h, required 0", d);
        end
        cpu_rd(1, 1, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_timeout: got %h, required 0", d);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_threshold();
        logic [31:0] d;
        cpu_wr(0, 0, 32'h0000_0401);
        cpu_wr(0, 1, 32'h0);
        for (int i = 0; i < 4; i++) begin
            ev[0] = 1'b1;
            tick();
            n_checks++;
            if (irq[0] !== (i == 3)) begin
                n_fail++;
                $display("FAIL thr4_irq_ev%0d: irq0=%b, required %b", i, irq[0], (i == 3));
            end
            if (i == 1) begin
                ev[0] = 1'b0;
                cpu_rd(0, 2, d);
                n_checks++;
                if (d !== 32'h0000_0202) begin
                    n_fail++;
                    $display("FAIL thr4_status_mid: got %h, required 00000202", d);
                end
            end
        end
        ev[0] = 1'b0;
        tick();
        n_checks++;
        if (irq[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL thr4_pulse_width: irq0=%b, required 0", irq[0]);
        end
        cpu_rd(0, 2, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL thr4_status_after: got %h, required 0", d);
        end
    endtask

    task automatic test_timeout_latch();
        logic [31:0] d;
        cpu_wr(1, 0, 32'h0000_0A03);
        cpu_wr(1, 1, 32'd20);
        cpu_rd(1, 1, d);
        n_checks++;
        if (d !== 32'd20) begin
            n_fail++;
            $display("FAIL timeout_readback: got %h, required 00000014", d);
        end
        ev[1] = 1'b1;
        tick();
        ev[1] = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_checks++;
            if (irq[1] !== (k == 20)) begin
                n_fail++;
                $display("FAIL timeout_irq_k%0d: irq1=%b, required %b", k, irq[1], (k == 20));
            end
        end
        repeat (5) tick();
        n_checks++;
        if (irq[1] !== 1'b1 || irq_any !== 1'b1) begin
            n_fail++;
            $display("FAIL latch_hold: irq1=%b any=%b, required 1/1", irq[1], irq_any);
        end
        cpu_rd(1, 2, d);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++;
            $display("FAIL latch_status: got %h, required 00000001", d);
        end
        cpu_wr(1, 2, 32'h1);
        n_checks++;
        if (irq[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL latch_clear: irq1=%b, required 0", irq[1]);
        end
    endtask

    task automatic test_clear_collision();
        cpu_wr(1, 0, 32'h0000_0103);
        ev[1] = 1'b1;
        tick();
        ev[1] = 1'b0;
        cpu_wr(1, 2, 32'h1);
        n_checks++;
        if (irq[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL set_wins_clear: irq1=%b, required 1", irq[1]);
        end
        tick();
        cpu_wr(1, 2, 32'h1);
        n_checks++;
        if (irq[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_after_collision: irq1=%b, required 0", irq[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        int fires;
        int first_fire;
        cpu_wr(2, 0, 32'h0000_0201);
        fires = 0;
        for (int i = 1; i <= 7; i++) begin
            ev[2] = (i <= 6);
            tick();
            if (irq[2] === 1'b1) fires++;
            n_checks++;
            if (irq[2] !== (i == 2 || i == 4 || i == 6)) begin
                n_fail++;
                $display("FAIL b2b_irq_t%0d: irq2=%b, required %b", i, irq[2], (i == 2 || i == 4 || i == 6));
            end
        end
        ev[2] = 1'b0;
        n_checks++;
        if (fires !== 3) begin
            n_fail++;
            $display("FAIL b2b_fire_count: got %0d, required 3", fires);
        end
        cpu_wr(2, 0, 32'h0000_FF01);
        fires = 0;
        first_fire = 0;
        for (int i = 1; i <= 302; i++) begin
            ev[2] = (i <= 300);
            tick();
            if (irq[2] === 1'b1) begin
                fires++;
                if (first_fire == 0) first_fire = i;
            end
        end
        ev[2] = 1'b0;
        n_checks++;
        if (fires !== 1 || first_fire !== 255) begin
            n_fail++;
            $display("FAIL sat_fires: count=%0d at=%0d, required 1 at 255", fires, first_fire);
        end
        cpu_rd(2, 2, d);
        n_checks++;
        if (d !== 32'h0000_2D02) begin
            n_fail++;
            $display("FAIL sat_status: got %h, required 00002d02", d);
        end
        cpu_wr(2, 0, 32'h0);
        cpu_rd(2, 2, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL disable_clears: got %h, required 0", d);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        ev[1] = 1'b1;
        tick();
        ev[1] = 1'b0;
        tick();
        n_checks++;
        if (irq[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_latch: irq1=%b, required 1", irq[1]);
        end
        cpu_wr(0, 0, 32'h0000_0A01);
        ev[0] = 1'b1;
        repeat (3) tick();
        ev[0] = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (irq !== 4'h0 || irq_any !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_irq: irq=%h any=%b, required 0/0", irq, irq_any);
        end
        cpu_rd(0, 0, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset_ctrl: got %h, required 0", d);
        end
        tick();
        rst_n = 1'b1;
        ev[0] = 1'b1;
        ev[1] = 1'b1;
        repeat (12) tick();
        ev = 4'h0;
        n_checks++;
        if (irq !== 4'h0) begin
            n_fail++;
            $display("FAIL events_after_reset: irq=%h, required 0", irq);
        end
        cpu_rd(0, 2, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL status_after_reset: got %h, required 0", d);
        end
    endtask

    task automatic test_multi();
        logic [31:0] d;
        logic [3:0]  exp;
        int          per [4];
        per[0] = 2;
        per[1] = 3;
        per[2] = 4;
        per[3] = 5;
        cpu_wr(0, 0, 32'h0000_0001);
        cpu_wr(1, 0, 32'h0000_0301);
        cpu_wr(2, 0, 32'h0000_0401);
        cpu_wr(3, 0, 32'h0000_0501);
        for (int t = 1; t <= 12; t++) begin
            ev = 4'hF;
            tick();
            for (int c = 0; c < 4; c++) exp[c] = ((t % per[c]) == 0);
            n_checks++;
            if (irq !== exp || irq_any !== (exp != 4'h0)) begin
                n_fail++;
                $display("FAIL multi_t%0d: irq=%h any=%b, required %h/%b", t, irq, irq_any, exp, (exp != 4'h0));
            end
        end
        ev = 4'h0;
        cpu_rd(0, 3, d);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reserved_read: got %h, required 0", d);
        end
        addr5 = 5'd16;
        wd    = 32'h0000_0301;
        wr5   = 1'b1;
        tick();
        addr5 = 5'd20;
        wd    = 32'h0000_0101;
        tick();
        wr5   = 1'b0;
        addr5 = 5'd16;
        rd5   = 1'b1;
        #1;
        n_checks++;
        if (rdata5 !== 32'h0000_0301) begin
            n_fail++;
            $display("FAIL ch4_ctrl_read: got %h, required 00000301", rdata5);
        end
        addr5 = 5'd20;
        #1;
        n_checks++;
        if (rdata5 !== 32'h0) begin
            n_fail++;
            $display("FAIL ch5_out_of_range: got %h, required 0", rdata5);
        end
        rd5 = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        ev       = 4'h0;
        wr       = 1'b0;
        rd       = 1'b0;
        addr     = 4'h0;
        wd       = 32'h0;
        ev5      = 5'h0;
        wr5      = 1'b0;
        rd5      = 1'b0;
        addr5    = 5'h0;
        test_reset();
        test_threshold();
        test_timeout_latch();
        test_clear_collision();
        test_back_to_back();
        test_reset_mid();
        test_multi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
